// File: rtl/htif_pcr_arbiter_pkg.sv
// Shared definitions for the HTIF PCR arbiter slice.
// Holds the default address/data widths (data width matches HTIF_PCR_WIDTH),
// the arbiter FSM state encoding, and the CSR address of the to_host register.
// The to_host address is also used by the testbenches.
package htif_pcr_arbiter_pkg;

    localparam int HTIF_PCR_WIDTH = 64;
    localparam int PCR_ADDR_W     = 12;

    localparam logic [11:0] CSR_ADDR_TO_HOST = 12'h780;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/htif_pcr_arbiter_rr.sv
// Combinational round-robin pick.
// Ports:
//   req       - request vector, one bit per requester
//   ptr       - requester index that has the highest priority this cycle
//   grant     - one-hot grant (all zero when nothing is requested)
//   grant_idx - encoded index of the granted requester (0 when none)
//   found     - at least one request is pending
module rr_arbiter
    import htif_pcr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       found
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Walk the ring from the far end back toward ptr so that the last hit,
    // which overrides earlier ones, is the first requester at or after ptr.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = idx[IDX_W-1:0];
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/htif_pcr_arbiter.sv
// Shares the single HTIF PCR request/response port among NUM_REQ requesters.
// One transaction is outstanding at a time; requests are registered before
// being driven downstream and the response is routed back to the issuer.
// Ports:
//   clk, reset                     - clock, synchronous active-low reset
//   req_valid/ready/rw/addr/data   - per-requester request channel (packed)
//   resp_valid/ready               - per-requester response handshake
//   resp_data                      - shared response data, qualified by resp_valid[i]
//   pcr_req_*                      - registered downstream request channel
//   pcr_resp_valid/ready/data      - downstream response channel
//   grant_id                       - owner of the current transaction
//   busy                           - a transaction is in progress
module htif_pcr_arbiter
    import htif_pcr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = PCR_ADDR_W,
    parameter int DATA_W  = HTIF_PCR_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ-1:0]          req_rw,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          resp_valid,
    input  logic [NUM_REQ-1:0]          resp_ready,
    output logic [DATA_W-1:0]           resp_data,
    output logic                        pcr_req_valid,
    input  logic                        pcr_req_ready,
    output logic                        pcr_req_rw,
    output logic [ADDR_W-1:0]           pcr_req_addr,
    output logic [DATA_W-1:0]           pcr_req_data,
    input  logic                        pcr_resp_valid,
    output logic                        pcr_resp_ready,
    input  logic [DATA_W-1:0]           pcr_resp_data,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] win_onehot;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic               accept;
    logic               resp_done;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (win_onehot),
        .grant_idx (win_idx),
        .found     (win_found)
    );

    assign accept    = (state == ST_IDLE) && win_found;
    assign resp_done = (state == ST_WAIT_RESP) && pcr_resp_valid && resp_ready[grant_id];

    assign pcr_req_valid = (state == ST_ISSUE);
    assign busy          = (state != ST_IDLE);
    assign resp_data     = pcr_resp_data;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (win_found)     state_next = ST_ISSUE;
            ST_ISSUE:     if (pcr_req_ready) state_next = ST_WAIT_RESP;
            ST_WAIT_RESP: if (resp_done)     state_next = ST_IDLE;
            default:                         state_next = ST_IDLE;
        endcase
    end

    // Handshake steering: accepts only in IDLE, response path only opened
    // toward the owner in WAIT_RESP so stray responses are held off.
    always_comb begin
        req_ready      = '0;
        resp_valid     = '0;
        pcr_resp_ready = 1'b0;
        if (state == ST_IDLE) begin
            req_ready = win_onehot;
        end
        if (state == ST_WAIT_RESP) begin
            resp_valid[grant_id] = pcr_resp_valid;
            pcr_resp_ready       = resp_ready[grant_id];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            grant_id     <= '0;
            pcr_req_rw   <= 1'b0;
            pcr_req_addr <= '0;
            pcr_req_data <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                grant_id     <= win_idx;
                pcr_req_rw   <= req_rw[win_idx];
                pcr_req_addr <= req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
                pcr_req_data <= req_data[int'(win_idx)*DATA_W +: DATA_W];
            end
            // Priority moves past the owner only once its response is taken.
            if (resp_done) begin
                rr_ptr <= (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_htif_pcr_arbiter.sv
// Directed self-checking bench for htif_pcr_arbiter with two requesters.
// The bench plays the downstream PCR port by hand in each scenario task.
module tb_htif_pcr_arbiter;
    import htif_pcr_arbiter_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 64;

    logic                      clk;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_rw;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [NUM_REQ-1:0]        resp_ready;
    logic [DATA_W-1:0]         resp_data;
    logic                      pcr_req_valid;
    logic                      pcr_req_ready;
    logic                      pcr_req_rw;
    logic [ADDR_W-1:0]         pcr_req_addr;
    logic [DATA_W-1:0]         pcr_req_data;
    logic                      pcr_resp_valid;
    logic                      pcr_resp_ready;
    logic [DATA_W-1:0]         pcr_resp_data;
    logic                      grant_id;
    logic                      busy;

    int n_checks = 0;
    int n_fail   = 0;

    htif_pcr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_rw         (req_rw),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .pcr_req_valid  (pcr_req_valid),
        .pcr_req_ready  (pcr_req_ready),
        .pcr_req_rw     (pcr_req_rw),
        .pcr_req_addr   (pcr_req_addr),
        .pcr_req_data   (pcr_req_data),
        .pcr_resp_valid (pcr_resp_valid),
        .pcr_resp_ready (pcr_resp_ready),
        .pcr_resp_data  (pcr_resp_data),
        .grant_id       (grant_id),
        .busy           (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one cycle; inputs are driven and outputs sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        req_valid      = '0;
        req_rw         = '0;
        req_addr       = '0;
        req_data       = '0;
        resp_ready     = '0;
        pcr_req_ready  = 1'b0;
        pcr_resp_valid = 1'b0;
        pcr_resp_data  = '0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Complete one read for requester r with a zero-wait downstream.
    task automatic run_txn(input int r, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] rdata);
        req_valid = NUM_REQ'(1) << r;
        req_rw[r] = 1'b0;
        req_addr[r*ADDR_W +: ADDR_W] = addr;
        pcr_req_ready = 1'b1;
        resp_ready = '1;
        tick();
        req_valid = '0;
        tick();
        pcr_resp_valid = 1'b1;
        pcr_resp_data  = rdata;
        tick();
        pcr_resp_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b0;
        tick();
        #1;
        n_checks++; if (pcr_req_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pcr_req_valid: got %0b expected 0", pcr_req_valid); end
        n_checks++; if (pcr_req_rw !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pcr_req_rw: got %0b expected 0", pcr_req_rw); end
        n_checks++; if (pcr_req_addr !== 12'h0) begin n_fail++; $display("[TB] FAIL reset_pcr_req_addr: got %h expected 000", pcr_req_addr); end
        n_checks++; if (pcr_req_data !== 64'h0) begin n_fail++; $display("[TB] FAIL reset_pcr_req_data: got %h expected 0", pcr_req_data); end
        n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_req_ready: got %b expected 00", req_ready); end
        n_checks++; if (resp_valid !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_resp_valid: got %b expected 00", resp_valid); end
        n_checks++; if (pcr_resp_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pcr_resp_ready: got %0b expected 0", pcr_resp_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
        n_checks++; if (grant_id !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_grant_id: got %0d expected 0", grant_id); end
        reset = 1'b1;
    endtask

    task automatic test_single_read();
        int hi_cnt;
        bit r1_seen;
        hi_cnt  = 0;
        r1_seen = 1'b0;
        do_reset();
        req_valid = 2'b01;
        req_rw    = 2'b00;
        req_addr[0 +: ADDR_W] = CSR_ADDR_TO_HOST;
        pcr_req_ready = 1'b1;
        resp_ready    = 2'b11;
        #1;
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("[TB] FAIL read_req_ready: got %b expected 01", req_ready); end
        tick();
        req_valid = 2'b00;
        #1;
        n_checks++; if (pcr_req_addr !== 12'h780) begin n_fail++; $display("[TB] FAIL read_addr: got %h expected 780", pcr_req_addr); end
        n_checks++; if (grant_id !== 1'b0) begin n_fail++; $display("[TB] FAIL read_grant: got %0d expected 0", grant_id); end
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin
                pcr_resp_valid = 1'b1;
                pcr_resp_data  = 64'h1;
                #1;
                n_checks++; if (resp_valid !== 2'b01) begin n_fail++; $display("[TB] FAIL read_resp_valid: got %b expected 01", resp_valid); end
                n_checks++; if (resp_data !== 64'h1) begin n_fail++; $display("[TB] FAIL read_resp_data: got %h expected 1", resp_data); end
                n_checks++; if (pcr_resp_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL read_pcr_resp_ready: got %0b expected 1", pcr_resp_ready); end
            end
            if (pcr_req_valid === 1'b1) hi_cnt++;
            if (resp_valid[1] !== 1'b0) r1_seen = 1'b1;
            tick();
        end
        pcr_resp_valid = 1'b0;
        #1;
        if (pcr_req_valid === 1'b1) hi_cnt++;
        if (resp_valid[1] !== 1'b0) r1_seen = 1'b1;
        n_checks++; if (hi_cnt != 1) begin n_fail++; $display("[TB] FAIL read_req_valid_cycles: got %0d expected 1", hi_cnt); end
        n_checks++; if (r1_seen) begin n_fail++; $display("[TB] FAIL read_resp1_quiet: got 1 expected 0"); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL read_done_busy: got %0b expected 0", busy); end
    endtask

    task automatic test_contention();
        logic            w;
        logic [63:0]     exp_tag;
        do_reset();
        resp_ready    = 2'b11;
        pcr_req_ready = 1'b1;
        req_valid     = 2'b11;
        for (int t = 0; t < 6; t++) begin
            w = 1'(t % 2);
            req_data[0 +: DATA_W]      = 64'hA0 + 64'(t);
            req_data[DATA_W +: DATA_W] = 64'hB0 + 64'(t);
            exp_tag = (w == 1'b1) ? 64'hB0 + 64'(t) : 64'hA0 + 64'(t);
            #1;
            n_checks++; if (req_ready !== (2'b01 << w)) begin n_fail++; $display("[TB] FAIL cont_req_ready[%0d]: got %b expected %b", t, req_ready, 2'b01 << w); end
            tick();
            n_checks++; if (grant_id !== w) begin n_fail++; $display("[TB] FAIL cont_grant[%0d]: got %0d expected %0d", t, grant_id, w); end
            n_checks++; if (pcr_req_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL cont_req_valid[%0d]: got %0b expected 1", t, pcr_req_valid); end
            n_checks++; if (pcr_req_data !== exp_tag) begin n_fail++; $display("[TB] FAIL cont_req_data[%0d]: got %h expected %h", t, pcr_req_data, exp_tag); end
            n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("[TB] FAIL cont_ready_busy[%0d]: got %b expected 00", t, req_ready); end
            tick();
            pcr_resp_valid = 1'b1;
            pcr_resp_data  = exp_tag;
            #1;
            n_checks++; if (resp_valid !== (2'b01 << w)) begin n_fail++; $display("[TB] FAIL cont_resp_valid[%0d]: got %b expected %b", t, resp_valid, 2'b01 << w); end
            n_checks++; if (resp_data !== exp_tag) begin n_fail++; $display("[TB] FAIL cont_resp_data[%0d]: got %h expected %h", t, resp_data, exp_tag); end
            tick();
            pcr_resp_valid = 1'b0;
        end
        req_valid = 2'b00;
    endtask

    task automatic test_backpressure();
        req_valid = 2'b10;
        req_rw    = 2'b00;
        req_addr[ADDR_W +: ADDR_W] = 12'h123;
        req_data[DATA_W +: DATA_W] = 64'h0123_4567_89AB_CDEF;
        pcr_req_ready = 1'b0;
        resp_ready    = 2'b11;
        tick();
        req_valid = 2'b00;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++; if (pcr_req_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_req_valid[%0d]: got %0b expected 1", c, pcr_req_valid); end
            n_checks++; if (pcr_req_addr !== 12'h123) begin n_fail++; $display("[TB] FAIL bp_req_addr[%0d]: got %h expected 123", c, pcr_req_addr); end
            n_checks++; if (pcr_req_data !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("[TB] FAIL bp_req_data[%0d]: got %h expected 0123456789abcdef", c, pcr_req_data); end
            tick();
        end
        pcr_req_ready = 1'b1;
        tick();
        pcr_resp_valid = 1'b1;
        pcr_resp_data  = 64'h77;
        resp_ready     = 2'b01;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++; if (pcr_resp_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_pcr_resp_ready[%0d]: got %0b expected 0", c, pcr_resp_ready); end
            n_checks++; if (resp_valid !== 2'b10) begin n_fail++; $display("[TB] FAIL bp_resp_valid[%0d]: got %b expected 10", c, resp_valid); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_busy[%0d]: got %0b expected 1", c, busy); end
            tick();
        end
        resp_ready = 2'b11;
        #1;
        n_checks++; if (pcr_resp_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_release: got %0b expected 1", pcr_resp_ready); end
        tick();
        pcr_resp_valid = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_complete: got busy %0b expected 0", busy); end
    endtask

    task automatic test_stray_response();
        req_valid      = 2'b00;
        pcr_resp_valid = 1'b1;
        pcr_resp_data  = 64'h99;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (pcr_resp_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL stray_pcr_resp_ready[%0d]: got %0b expected 0", c, pcr_resp_ready); end
            n_checks++; if (resp_valid !== 2'b00) begin n_fail++; $display("[TB] FAIL stray_resp_valid[%0d]: got %b expected 00", c, resp_valid); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL stray_busy[%0d]: got %0b expected 0", c, busy); end
            tick();
        end
        pcr_resp_valid = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        // Requester 0 completes first so the priority pointer moves to 1.
        run_txn(0, 12'h100, 64'h5);
        req_valid = 2'b10;
        req_addr[ADDR_W +: ADDR_W] = 12'h200;
        req_data[DATA_W +: DATA_W] = 64'hCAFE;
        pcr_req_ready = 1'b1;
        tick();
        req_valid = 2'b00;
        tick();
        pcr_resp_valid = 1'b1;
        pcr_resp_data  = 64'h55;
        resp_ready     = 2'b00;
        #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_pre_busy: got %0b expected 1", busy); end
        reset = 1'b0;
        tick();
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_busy: got %0b expected 0", busy); end
        n_checks++; if (resp_valid !== 2'b00) begin n_fail++; $display("[TB] FAIL rst_resp_valid: got %b expected 00", resp_valid); end
        n_checks++; if (pcr_resp_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_pcr_resp_ready: got %0b expected 0", pcr_resp_ready); end
        n_checks++; if (pcr_req_addr !== 12'h0) begin n_fail++; $display("[TB] FAIL rst_addr: got %h expected 000", pcr_req_addr); end
        n_checks++; if (pcr_req_data !== 64'h0) begin n_fail++; $display("[TB] FAIL rst_data: got %h expected 0", pcr_req_data); end
        n_checks++; if (grant_id !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_grant: got %0d expected 0", grant_id); end
        n_checks++; if (pcr_req_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_req_valid: got %0b expected 0", pcr_req_valid); end
        reset          = 1'b1;
        pcr_resp_valid = 1'b0;
        resp_ready     = 2'b11;
        req_valid      = 2'b11;
        #1;
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("[TB] FAIL rst_ptr_cleared: got %b expected 01", req_ready); end
        req_valid = 2'b10;
        req_addr[ADDR_W +: ADDR_W] = 12'h201;
        req_data[DATA_W +: DATA_W] = 64'h42;
        #1;
        n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("[TB] FAIL rst_req1_ready: got %b expected 10", req_ready); end
        tick();
        req_valid = 2'b00;
        n_checks++; if (grant_id !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_req1_grant: got %0d expected 1", grant_id); end
        n_checks++; if (pcr_req_addr !== 12'h201) begin n_fail++; $display("[TB] FAIL rst_req1_addr: got %h expected 201", pcr_req_addr); end
        tick();
        pcr_resp_valid = 1'b1;
        pcr_resp_data  = 64'h66;
        #1;
        n_checks++; if (resp_valid !== 2'b10) begin n_fail++; $display("[TB] FAIL rst_req1_resp_valid: got %b expected 10", resp_valid); end
        n_checks++; if (resp_data !== 64'h66) begin n_fail++; $display("[TB] FAIL rst_req1_resp_data: got %h expected 66", resp_data); end
        tick();
        pcr_resp_valid = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_req1_done: got busy %0b expected 0", busy); end
    endtask

    task automatic test_write();
        req_valid = 2'b10;
        req_rw    = 2'b10;
        req_addr[ADDR_W +: ADDR_W] = 12'h781;
        req_data[DATA_W +: DATA_W] = 64'hDEAD_BEEF;
        pcr_req_ready = 1'b1;
        resp_ready    = 2'b11;
        tick();
        req_valid = 2'b00;
        req_rw    = 2'b00;
        n_checks++; if (pcr_req_rw !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_rw: got %0b expected 1", pcr_req_rw); end
        n_checks++; if (pcr_req_addr !== 12'h781) begin n_fail++; $display("[TB] FAIL wr_addr: got %h expected 781", pcr_req_addr); end
        n_checks++; if (pcr_req_data !== 64'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL wr_data: got %h expected deadbeef", pcr_req_data); end
        tick();
        pcr_resp_valid = 1'b1;
        pcr_resp_data  = 64'h1234;
        #1;
        n_checks++; if (resp_valid !== 2'b10) begin n_fail++; $display("[TB] FAIL wr_resp_valid: got %b expected 10", resp_valid); end
        n_checks++; if (resp_data !== 64'h1234) begin n_fail++; $display("[TB] FAIL wr_resp_data: got %h expected 1234", resp_data); end
        tick();
        pcr_resp_valid = 1'b0;
    endtask

    initial begin
        $display("[TB] htif_pcr_arbiter directed test start");
        test_reset();
        test_single_read();
        test_contention();
        test_backpressure();
        test_stray_response();
        test_reset_mid_op();
        test_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
